// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multicycle RV32I control FSM.
// Holds the state enum, the ALU operation select codes (identical to the
// ALU's own encoding), the opcode constants, the mux select encodings and
// the bundle of registered control outputs.
// No ports (package).
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_LUI
  } statetype;

  // ALU operation select, must stay in lockstep with the ALU
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_PASSB = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  // Class of ALU operation chosen by the FSM before funct decoding
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Control outputs that are pure functions of the FSM state
  typedef struct packed {
    logic [2:0] alu_control;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       instr_done;
  } ctrl_t;

  // Immediate format is a direct function of the opcode
  function automatic logic [2:0] imm_src_for(input logic [6:0] op);
    logic [2:0] imm;
    imm = IMM_I;
    case (op)
      OP_LOAD, OP_ITYPE: imm = IMM_I;
      OP_STORE:          imm = IMM_S;
      OP_BRANCH:         imm = IMM_B;
      OP_JAL:            imm = IMM_J;
      OP_LUI:            imm = IMM_U;
      default:           imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: bundle between the control FSM and the datapath.
// Datapath -> controller: op, funct3, funct7b5 (from the instruction
// register) and Zero (ALU flag).
// Controller -> datapath: ALU select, operand/result/address mux selects,
// immediate format, write enables and the InstrDone/IllegalInstr pulses.
// master modport: the controller. slave modport: the datapath.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic [2:0] ALUControl;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [2:0] ImmSrc;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       InstrDone;
  logic       IllegalInstr;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output ALUControl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc,
           IRWrite, PCWrite, RegWrite, MemWrite, InstrDone, IllegalInstr
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  ALUControl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc,
           IRWrite, PCWrite, RegWrite, MemWrite, InstrDone, IllegalInstr
  );
endinterface

// File: rtl/alu_decoder.sv
// alu_decoder: combinational ALU operation decode.
// Ports: alu_op (operation class from the FSM), funct3, funct7b5, op5
// (instruction[5], separates R-type from I-type) -> alu_control and illegal.
// Optional feature macro CTRL_BNE_EN: when defined, branch funct3 001 (bne)
// is legal; otherwise only beq (funct3 000) is.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control,
  output logic       illegal
);

  // Map the operation class and funct fields onto an ALU select; encodings
  // outside the supported subset raise illegal so DECODE can abandon them.
  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: begin
        alu_control = ALU_SUB;
`ifdef CTRL_BNE_EN
        illegal = (funct3 != 3'b000) && (funct3 != 3'b001);
`else
        illegal = (funct3 != 3'b000);
`endif
      end
      ALUOP_FUNCT: begin
        case (funct3)
          // subtraction only exists in the register form (addi has no subi)
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM for the multicycle RV32I datapath.
// Ports: clk (rising edge), reset (synchronous, active high), bus (master
// modport of multicycle_controller_if carrying op/funct3/funct7b5/Zero in and
// all ALU, mux, immediate and write-enable controls out).
// Optional feature macro CTRL_BNE_EN: accepts bne and makes the branch state
// load the PC on Zero XOR funct3[0]; without it bne is flagged illegal.
module multicycle_controller
  import ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  multicycle_controller_if.master bus
);

  statetype   state;
  statetype   next_state;
  ctrl_t      ctrl_q;
  ctrl_t      ctrl_next;
  logic [1:0] alu_op;
  logic       op_known;
  logic [2:0] dec_alu_control;
  logic       dec_illegal;
  logic       decode_illegal;
  logic       branch_taken;

  // Control word for each state; exec_alu is the decoded operation used by
  // the two execute states.
  function automatic ctrl_t outputs_for(input statetype s, input logic [2:0] exec_alu);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.adr_src     = 1'b0;
        c.ir_write    = 1'b1;
        c.alu_src_a   = SRCA_PC;
        c.alu_src_b   = SRCB_FOUR;
        c.alu_control = ALU_ADD;
        c.result_src  = RES_ALURESULT;
        c.pc_write    = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a   = SRCA_OLDPC;
        c.alu_src_b   = SRCB_IMM;
        c.alu_control = ALU_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a   = SRCA_RS1;
        c.alu_src_b   = SRCB_IMM;
        c.alu_control = ALU_ADD;
      end
      S_MEMREAD: begin
        c.result_src = RES_ALUOUT;
        c.adr_src    = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = RES_MEMDATA;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        c.result_src = RES_ALUOUT;
        c.adr_src    = 1'b1;
        c.mem_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_EXECUTER: begin
        c.alu_src_a   = SRCA_RS1;
        c.alu_src_b   = SRCB_RS2;
        c.alu_control = exec_alu;
      end
      S_EXECUTEI: begin
        c.alu_src_a   = SRCA_RS1;
        c.alu_src_b   = SRCB_IMM;
        c.alu_control = exec_alu;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      // PC load depends on Zero from this very cycle, so it is added
      // combinationally at the output instead of being registered here
      S_BEQ: begin
        c.alu_src_a   = SRCA_RS1;
        c.alu_src_b   = SRCB_RS2;
        c.alu_control = ALU_SUB;
        c.result_src  = RES_ALUOUT;
        c.instr_done  = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a   = SRCA_OLDPC;
        c.alu_src_b   = SRCB_FOUR;
        c.alu_control = ALU_ADD;
        c.result_src  = RES_ALUOUT;
        c.pc_write    = 1'b1;
      end
      S_LUI: begin
        c.alu_src_b   = SRCB_IMM;
        c.alu_control = ALU_PASSB;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Classify the opcode: which ALU operation class it needs and whether the
  // controller supports it at all.
  always_comb begin
    alu_op   = ALUOP_ADD;
    op_known = 1'b1;
    case (bus.op)
      OP_RTYPE, OP_ITYPE:        alu_op = ALUOP_FUNCT;
      OP_BRANCH:                 alu_op = ALUOP_SUB;
      OP_LOAD, OP_STORE, OP_JAL,
      OP_LUI:                    alu_op = ALUOP_ADD;
      default:                   op_known = 1'b0;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .op5         (bus.op[5]),
    .alu_control (dec_alu_control),
    .illegal     (dec_illegal)
  );

  assign decode_illegal = !op_known || dec_illegal;

  // Next-state logic; illegal encodings are caught while still in DECODE so
  // no execute state ever runs with an unsupported funct3.
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH: next_state = S_DECODE;
      S_DECODE: begin
        if (!decode_illegal) begin
          case (bus.op)
            OP_LOAD, OP_STORE: next_state = S_MEMADR;
            OP_RTYPE:          next_state = S_EXECUTER;
            OP_ITYPE:          next_state = S_EXECUTEI;
            OP_BRANCH:         next_state = S_BEQ;
            OP_JAL:            next_state = S_JAL;
            OP_LUI:            next_state = S_LUI;
            default:           next_state = S_FETCH;
          endcase
        end
      end
      S_MEMADR:  next_state = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: next_state = S_MEMWB;
      S_EXECUTER, S_EXECUTEI, S_JAL, S_LUI: next_state = S_ALUWB;
      default:   next_state = S_FETCH;
    endcase
  end

  // Outputs are registered alongside the state by computing the control
  // word of the state being entered.
  always_comb begin
    ctrl_next = outputs_for(next_state, dec_alu_control);
  end

  // State and registered control word; unused encodings fall back to FETCH
  // through the next-state default.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_FETCH;
      ctrl_q <= outputs_for(S_FETCH, ALU_ADD);
    end else begin
      state  <= next_state;
      ctrl_q <= ctrl_next;
    end
  end

`ifdef CTRL_BNE_EN
  assign branch_taken = bus.Zero ^ bus.funct3[0];
`else
  assign branch_taken = bus.Zero;
`endif

  assign bus.ALUControl = ctrl_q.alu_control;
  assign bus.ALUSrcA    = ctrl_q.alu_src_a;
  assign bus.ALUSrcB    = ctrl_q.alu_src_b;
  assign bus.ResultSrc  = ctrl_q.result_src;
  assign bus.AdrSrc     = ctrl_q.adr_src;
  assign bus.ImmSrc     = imm_src_for(bus.op);

  // Enables are masked by reset directly so a reset landing mid-instruction
  // suppresses any write in that same cycle.
  assign bus.IRWrite      = ctrl_q.ir_write   && !reset;
  assign bus.PCWrite      = (ctrl_q.pc_write || (state == S_BEQ && branch_taken)) && !reset;
  assign bus.RegWrite     = ctrl_q.reg_write  && !reset;
  assign bus.MemWrite     = ctrl_q.mem_write  && !reset;
  assign bus.InstrDone    = ctrl_q.instr_done && !reset;
  assign bus.IllegalInstr = (state == S_DECODE) && decode_illegal && !reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: self-checking bench for multicycle_controller.
// Each instruction is held on op/funct3/funct7b5 while the bench walks it
// cycle by cycle against a reference model built from the instruction class
// and its step number; Zero and occasional mid-instruction resets are random.
// Honours CTRL_BNE_EN the same way the design does.
module tb_multicycle_controller;

`ifdef CTRL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  typedef enum {C_LOAD, C_STORE, C_R, C_I, C_BR, C_JAL, C_LUI, C_ILL} classT;

  // -1 in a mux field means that state leaves it unspecified
  typedef struct {
    int alu, srca, srcb, res, adr;
    int irw, pcw, rw, mw, done, ill;
  } expT;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  multicycle_controller_if bus();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic bit legalFunct(input logic [2:0] f3);
    return (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

  function automatic classT classify(input logic [6:0] o, input logic [2:0] f3);
    case (o)
      7'h03:   return C_LOAD;
      7'h23:   return C_STORE;
      7'h33:   return legalFunct(f3) ? C_R : C_ILL;
      7'h13:   return legalFunct(f3) ? C_I : C_ILL;
      7'h63:   return ((f3 == 3'd0) || (BNE_EN && f3 == 3'd1)) ? C_BR : C_ILL;
      7'h6f:   return C_JAL;
      7'h37:   return C_LUI;
      default: return C_ILL;
    endcase
  endfunction

  function automatic int lengthOf(input classT c);
    case (c)
      C_LOAD:  return 5;
      C_BR:    return 3;
      C_ILL:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int aluFor(input classT c, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (c == C_R && f7) ? 1 : 0;
      3'd2:    return 5;
      3'd6:    return 3;
      3'd7:    return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int immFor(input logic [6:0] o);
    case (o)
      7'h03, 7'h13: return 0;
      7'h23:        return 1;
      7'h63:        return 2;
      7'h6f:        return 3;
      7'h37:        return 4;
      default:      return 0;
    endcase
  endfunction

  function automatic expT expectAt(input classT c, input logic [2:0] f3,
                                   input logic f7, input logic z, input int step);
    expT e;
    e.alu = -1; e.srca = -1; e.srcb = -1; e.res = -1; e.adr = -1;
    e.irw = 0; e.pcw = 0; e.rw = 0; e.mw = 0; e.done = 0; e.ill = 0;
    if (step == 0) begin
      e.adr = 0; e.irw = 1; e.srca = 0; e.srcb = 2; e.alu = 0; e.res = 2; e.pcw = 1;
    end else if (step == 1) begin
      e.srca = 1; e.srcb = 1; e.alu = 0; e.ill = (c == C_ILL) ? 1 : 0;
    end else if (step == 2) begin
      case (c)
        C_LOAD, C_STORE: begin e.srca = 2; e.srcb = 1; e.alu = 0; end
        C_R:   begin e.srca = 2; e.srcb = 0; e.alu = aluFor(c, f3, f7); end
        C_I:   begin e.srca = 2; e.srcb = 1; e.alu = aluFor(c, f3, f7); end
        C_BR:  begin
          e.srca = 2; e.srcb = 0; e.alu = 1; e.res = 0; e.done = 1;
          e.pcw = int'(z ^ (f3 == 3'd1));
        end
        C_JAL: begin e.srca = 1; e.srcb = 2; e.alu = 0; e.res = 0; e.pcw = 1; end
        C_LUI: begin e.srcb = 1; e.alu = 4; end
        default: ;
      endcase
    end else if (step == 3) begin
      case (c)
        C_LOAD:  begin e.res = 0; e.adr = 1; end
        C_STORE: begin e.res = 0; e.adr = 1; e.mw = 1; e.done = 1; end
        default: begin e.res = 0; e.rw = 1; e.done = 1; end
      endcase
    end else begin
      e.res = 1; e.rw = 1; e.done = 1;
    end
    return e;
  endfunction

  task automatic checkEnablesLow(input string tag);
    checkOutput({tag, " irw"},  bus.IRWrite,      0);
    checkOutput({tag, " pcw"},  bus.PCWrite,      0);
    checkOutput({tag, " rw"},   bus.RegWrite,     0);
    checkOutput({tag, " mw"},   bus.MemWrite,     0);
    checkOutput({tag, " done"}, bus.InstrDone,    0);
    checkOutput({tag, " ill"},  bus.IllegalInstr, 0);
  endtask

  // Runs one instruction from FETCH to its last state. zeroForce < 0 means
  // random Zero each cycle; resetAt >= 0 pulses reset at that step, after
  // which the instruction restarts from FETCH.
  task automatic applyStimulus(input string name, input logic [6:0] o,
                               input logic [2:0] f3, input logic f7,
                               input int zeroForce, input int resetAt);
    classT c;
    int    n;
    int    rs;
    expT   e;
    string t;
    c  = classify(o, f3);
    n  = lengthOf(c);
    rs = resetAt;
    bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7;
    for (int s = 0; s < n; s++) begin
      bus.Zero = (zeroForce < 0) ? 1'($urandom_range(0, 1)) : 1'(zeroForce);
      if (s == rs) begin
        reset = 1'b1;
        #1;
        checkEnablesLow($sformatf("%s rst s%0d", name, s));
        @(posedge clk);
        #1;
        reset = 1'b0;
        rs = -1;
        s = -1;
        continue;
      end
      #1;
      e = expectAt(c, f3, f7, bus.Zero, s);
      t = $sformatf("%s s%0d", name, s);
      checkOutput({t, " imm"},  bus.ImmSrc,       immFor(o));
      checkOutput({t, " irw"},  bus.IRWrite,      e.irw);
      checkOutput({t, " pcw"},  bus.PCWrite,      e.pcw);
      checkOutput({t, " rw"},   bus.RegWrite,     e.rw);
      checkOutput({t, " mw"},   bus.MemWrite,     e.mw);
      checkOutput({t, " done"}, bus.InstrDone,    e.done);
      checkOutput({t, " ill"},  bus.IllegalInstr, e.ill);
      if (e.alu  >= 0) checkOutput({t, " alu"},  bus.ALUControl, e.alu);
      if (e.srca >= 0) checkOutput({t, " srca"}, bus.ALUSrcA,    e.srca);
      if (e.srcb >= 0) checkOutput({t, " srcb"}, bus.ALUSrcB,    e.srcb);
      if (e.res  >= 0) checkOutput({t, " res"},  bus.ResultSrc,  e.res);
      if (e.adr  >= 0) checkOutput({t, " adr"},  bus.AdrSrc,     e.adr);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [6:0] ops [0:7];
    logic [6:0] o;
    int         k;
    int         ra;
    ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h33; ops[3] = 7'h13;
    ops[4] = 7'h63; ops[5] = 7'h6f; ops[6] = 7'h37; ops[7] = 7'h7f;

    reset = 1'b1;
    bus.op = 7'h00; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0; bus.Zero = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkEnablesLow("reset");
    reset = 1'b0;

    applyStimulus("lw",     7'h03, 3'd2, 1'b0, -1, -1);
    applyStimulus("sub",    7'h33, 3'd0, 1'b1, -1, -1);
    applyStimulus("slt",    7'h33, 3'd2, 1'b0, -1, -1);
    applyStimulus("addi",   7'h13, 3'd0, 1'b1, -1, -1);
    applyStimulus("beqz1",  7'h63, 3'd0, 1'b0,  1, -1);
    applyStimulus("beqz0",  7'h63, 3'd0, 1'b0,  0, -1);
    applyStimulus("lui",    7'h37, 3'd0, 1'b0, -1, -1);
    applyStimulus("jal",    7'h6f, 3'd0, 1'b0, -1, -1);
    applyStimulus("bad",    7'h7f, 3'd0, 1'b0, -1, -1);
    applyStimulus("bnez1",  7'h63, 3'd1, 1'b0,  1, -1);
    applyStimulus("bnez0",  7'h63, 3'd1, 1'b0,  0, -1);
    applyStimulus("swrst",  7'h23, 3'd2, 1'b0, -1,  3);
    applyStimulus("sw",     7'h23, 3'd2, 1'b0, -1, -1);

    repeat (400) begin
      k  = $urandom_range(0, 8);
      o  = (k == 8) ? 7'($urandom) : ops[k];
      ra = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1;
      applyStimulus("rnd", o, 3'($urandom), 1'($urandom), -1, ra);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
